// File: rtl/floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// floor_request_scheduler
// Request-side front end for the elevator controller. It debounces the raw call
// buttons and latches them as pending requests. It picks the next target floor
// in SCAN order and drives it to the controller. When the controller reports
// arrival it holds the door open for a fixed dwell, then clears the served
// request.
//
// Ports:
//   clk             in   clock
//   rst_n           in   asynchronous reset, active-high (historical name)
//   call_btn        in   raw asynchronous call buttons, bit f = floor f
//   current_floor   in   floor reported by the elevator controller
//   idle            in   controller is stationary
//   requested_floor out  target floor handed to the controller
//   pending         out  latched outstanding requests
//   direction_up    out  SCAN sweep direction, 1 = up
//   door_open       out  high while dwelling at a served floor
// -----------------------------------------------------------------------------
module floor_request_scheduler #(
    parameter int NUM_FLOORS      = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DWELL_CYCLES    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  idle,
    output logic [3:0]            requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  direction_up,
    output logic                  door_open
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_TRAVEL, ST_DWELL} state_t;

    // One-hot mask for a floor index; out-of-range floors give an empty mask.
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [3:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (f == 4'(i)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [NUM_FLOORS-1:0] sync1_r, sync2_r, pending_r;
    logic [CW-1:0]         deb_cnt_r [NUM_FLOORS];
    state_t                state_r, state_s;
    logic [3:0]            req_r, req_s;
    logic                  dir_r, dir_s, door_r, door_s;
    logic [DW-1:0]         dwell_cnt_r, dwell_cnt_s;

    logic [NUM_FLOORS-1:0] press_s, clr_mask_s, absorb_mask_s, pending_s;
    logic                  cur_valid_s, cur_pending_s, arrival_s;
    logic                  found_above_s, found_below_s;
    logic [3:0]            lowest_above_s, highest_below_s;

    // Two-flop synchronizers for the raw buttons.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_r <= {NUM_FLOORS{1'b0}};
            sync2_r <= {NUM_FLOORS{1'b0}};
        end else begin
            sync1_r <= call_btn;
            sync2_r <= sync1_r;
        end
    end

    // Per-button stability counters: count while high, saturate, clear when low.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                deb_cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (!sync2_r[i]) begin
                    deb_cnt_r[i] <= {CW{1'b0}};
                end else if (deb_cnt_r[i] != CW'(DEBOUNCE_CYCLES)) begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + CW'(1);
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i];
                end
            end
        end
    end

    // Press event fires once, on the cycle the counter steps onto the threshold.
    always_comb begin
        press_s = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            press_s[i] = sync2_r[i] && (deb_cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    // Nearest pending floor above and below the current floor.
    always_comb begin
        cur_valid_s     = ({1'b0, current_floor} < 5'(NUM_FLOORS));
        cur_pending_s   = ((pending_r & floor_mask(current_floor)) != {NUM_FLOORS{1'b0}});
        found_above_s   = 1'b0;
        found_below_s   = 1'b0;
        lowest_above_s  = 4'd0;
        highest_below_s = 4'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_r[i] && (5'(i) > {1'b0, current_floor})) begin
                found_above_s  = 1'b1;
                lowest_above_s = 4'(i);
            end else begin
                found_above_s  = found_above_s;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_r[i] && (5'(i) < {1'b0, current_floor})) begin
                found_below_s   = 1'b1;
                highest_below_s = 4'(i);
            end else begin
                found_below_s   = found_below_s;
            end
        end
        arrival_s = idle && cur_valid_s && (current_floor == req_r);
    end

    // Next-state, target selection, retargeting and dwell control.
    always_comb begin
        state_s       = state_r;
        req_s         = req_r;
        dir_s         = dir_r;
        dwell_cnt_s   = dwell_cnt_r;
        clr_mask_s    = {NUM_FLOORS{1'b0}};
        absorb_mask_s = {NUM_FLOORS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pending_r != {NUM_FLOORS{1'b0}}) begin
                    state_s = ST_SELECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                state_s = ST_TRAVEL;
                if (pending_r == {NUM_FLOORS{1'b0}}) begin
                    state_s = ST_IDLE;
                end else if (cur_pending_s) begin
                    req_s = current_floor;
                end else if (dir_r) begin
                    if (found_above_s) begin
                        req_s = lowest_above_s;
                    end else begin
                        req_s = highest_below_s;
                        dir_s = 1'b0;
                    end
                end else begin
                    if (found_below_s) begin
                        req_s = highest_below_s;
                    end else begin
                        req_s = lowest_above_s;
                        dir_s = 1'b1;
                    end
                end
            end
            ST_TRAVEL: begin
                if (arrival_s) begin
                    state_s     = ST_DWELL;
                    clr_mask_s  = floor_mask(req_r);
                    dwell_cnt_s = {DW{1'b0}};
                end else if (!cur_valid_s) begin
                    req_s = req_r;
                end else if ((req_r > current_floor) && found_above_s && (lowest_above_s < req_r)) begin
                    req_s = lowest_above_s;
                end else if ((req_r < current_floor) && found_below_s && (highest_below_s > req_r)) begin
                    req_s = highest_below_s;
                end else begin
                    req_s = req_r;
                end
            end
            ST_DWELL: begin
                absorb_mask_s = floor_mask(req_r);
                if ((press_s & absorb_mask_s) != {NUM_FLOORS{1'b0}}) begin
                    dwell_cnt_s = {DW{1'b0}};
                end else if (dwell_cnt_r == DW'(DWELL_CYCLES - 1)) begin
                    dwell_cnt_s = {DW{1'b0}};
                    state_s     = ST_IDLE;
                end else begin
                    dwell_cnt_s = dwell_cnt_r + DW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Clear beats a same-cycle set; the dwelling floor never re-latches.
        pending_s = (pending_r | (press_s & ~absorb_mask_s)) & ~clr_mask_s;
        if ((state_r == ST_DWELL) && (state_s == ST_IDLE) && (pending_s != {NUM_FLOORS{1'b0}})) begin
            state_s = ST_SELECT;
        end else begin
            state_s = state_s;
        end
        door_s = (state_s == ST_DWELL);
    end

    // State, request and output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r     <= ST_IDLE;
            req_r       <= 4'd0;
            dir_r       <= 1'b1;
            door_r      <= 1'b0;
            dwell_cnt_r <= {DW{1'b0}};
            pending_r   <= {NUM_FLOORS{1'b0}};
        end else begin
            state_r     <= state_s;
            req_r       <= req_s;
            dir_r       <= dir_s;
            door_r      <= door_s;
            dwell_cnt_r <= dwell_cnt_s;
            pending_r   <= pending_s;
        end
    end

    assign requested_floor = req_r;
    assign pending         = pending_r;
    assign direction_up    = dir_r;
    assign door_open       = door_r;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for floor_request_scheduler (default parameters:
// 8 floors, debounce 4, dwell 16). Inputs change and outputs are sampled 1 time
// unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_floor_request_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] call_btn;
    logic [3:0] current_floor;
    logic       idle;
    logic [3:0] requested_floor;
    logic [7:0] pending;
    logic       direction_up;
    logic       door_open;

    int n_checks = 0;
    int n_fail   = 0;

    floor_request_scheduler #(
        .NUM_FLOORS(8), .DEBOUNCE_CYCLES(4), .DWELL_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .call_btn(call_btn),
        .current_floor(current_floor), .idle(idle),
        .requested_floor(requested_floor), .pending(pending),
        .direction_up(direction_up), .door_open(door_open)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Door stays high for 16 samples from the entry edge, low on the 17th.
    task automatic dwell_done(input string tag);
        tick(15);
        chk({tag, "_door_last"}, 32'(door_open), 32'd1);
        tick(1);
        chk({tag, "_door_off"}, 32'(door_open), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; call_btn = 8'h00; current_floor = 4'd0; idle = 1'b1;
        tick(2);
        chk("rst_req", 32'(requested_floor), 32'd0);
        chk("rst_pend", 32'(pending), 32'h00);
        chk("rst_dir", 32'(direction_up), 32'd1);
        chk("rst_door", 32'(door_open), 32'd0);
        rst_n = 1'b0;

        // 1: single press on floor 5 from floor 0.
        call_btn = 8'h20;
        tick(5);
        chk("t1_pend_early", 32'(pending), 32'h00);
        tick(1);
        chk("t1_pend", 32'(pending), 32'h20);
        tick(1);
        chk("t1_req_select", 32'(requested_floor), 32'd0);
        tick(1);
        chk("t1_req", 32'(requested_floor), 32'd5);
        chk("t1_dir", 32'(direction_up), 32'd1);
        current_floor = 4'd5; idle = 1'b1;
        tick(1);
        chk("t1_door_on", 32'(door_open), 32'd1);
        chk("t1_pend_clr", 32'(pending), 32'h00);
        call_btn = 8'h00;
        dwell_done("t1");
        chk("t1_req_hold", 32'(requested_floor), 32'd5);

        // 2: 3-cycle glitch on floor 2 never registers.
        call_btn = 8'h04;
        tick(3);
        call_btn = 8'h00;
        tick(8);
        chk("t2_pend", 32'(pending), 32'h00);
        chk("t2_req", 32'(requested_floor), 32'd5);

        // 3: at floor 3 going up with {1,6} pending.
        current_floor = 4'd3; idle = 1'b1;
        call_btn = 8'h42;
        tick(6);
        chk("t3_pend", 32'(pending), 32'h42);
        call_btn = 8'h00;
        tick(2);
        chk("t3_req6", 32'(requested_floor), 32'd6);
        chk("t3_dir_up", 32'(direction_up), 32'd1);
        current_floor = 4'd6;
        tick(1);
        chk("t3_door6", 32'(door_open), 32'd1);
        chk("t3_pend6", 32'(pending), 32'h02);
        dwell_done("t3_d6");
        tick(1);
        chk("t3_req1", 32'(requested_floor), 32'd1);
        chk("t3_dir_dn", 32'(direction_up), 32'd0);
        current_floor = 4'd4; idle = 1'b0;
        call_btn = 8'h21;
        tick(6);
        chk("t3_pend_50", 32'(pending), 32'h23);
        call_btn = 8'h00;
        tick(1);
        chk("t3_no_retarget", 32'(requested_floor), 32'd1);
        current_floor = 4'd1; idle = 1'b1;
        tick(1);
        chk("t3_pend1", 32'(pending), 32'h21);
        dwell_done("t3_d1");
        tick(1);
        chk("t3_req0", 32'(requested_floor), 32'd0);
        chk("t3_dir_dn2", 32'(direction_up), 32'd0);
        current_floor = 4'd0;
        tick(1);
        chk("t3_pend0", 32'(pending), 32'h20);
        dwell_done("t3_d0");
        tick(1);
        chk("t3_req5", 32'(requested_floor), 32'd5);
        chk("t3_dir_up2", 32'(direction_up), 32'd1);
        current_floor = 4'd5;
        tick(1);
        dwell_done("t3_d5");
        chk("t3_pend_end", 32'(pending), 32'h00);

        // 4: travelling 0->6, press floor 4 while passing floor 2.
        current_floor = 4'd0; idle = 1'b1;
        call_btn = 8'h40;
        tick(6);
        call_btn = 8'h00;
        tick(2);
        chk("t4_req6", 32'(requested_floor), 32'd6);
        current_floor = 4'd2; idle = 1'b0;
        call_btn = 8'h10;
        tick(6);
        chk("t4_pend", 32'(pending), 32'h50);
        chk("t4_req_pre", 32'(requested_floor), 32'd6);
        call_btn = 8'h00;
        tick(1);
        chk("t4_retarget", 32'(requested_floor), 32'd4);
        current_floor = 4'd4; idle = 1'b1;
        tick(1);
        chk("t4_door", 32'(door_open), 32'd1);
        chk("t4_pend4", 32'(pending), 32'h40);

        // 5: press floor 4 during its own dwell: absorbed, dwell restarts.
        call_btn = 8'h10;
        tick(6);
        chk("t5_absorb", 32'(pending), 32'h40);
        chk("t5_door", 32'(door_open), 32'd1);
        call_btn = 8'h00;
        tick(10);
        chk("t5_extended", 32'(door_open), 32'd1);
        tick(5);
        chk("t5_door_last", 32'(door_open), 32'd1);
        tick(1);
        chk("t5_door_off", 32'(door_open), 32'd0);
        tick(1);
        chk("t5_req6", 32'(requested_floor), 32'd6);

        // 6: asynchronous reset mid-travel.
        idle = 1'b0;
        call_btn = 8'h0C;
        tick(6);
        chk("t6_pend", 32'(pending), 32'h4C);
        call_btn = 8'h00;
        tick(1);
        chk("t6_req", 32'(requested_floor), 32'd6);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t6_rst_pend", 32'(pending), 32'h00);
        chk("t6_rst_req", 32'(requested_floor), 32'd0);
        chk("t6_rst_door", 32'(door_open), 32'd0);
        chk("t6_rst_dir", 32'(direction_up), 32'd1);
        tick(1);
        rst_n = 1'b0;
        current_floor = 4'd0; idle = 1'b1;
        tick(20);
        chk("t6_quiet_pend", 32'(pending), 32'h00);
        chk("t6_quiet_req", 32'(requested_floor), 32'd0);
        chk("t6_quiet_door", 32'(door_open), 32'd0);
        call_btn = 8'h08;
        tick(6);
        chk("t6_new_pend", 32'(pending), 32'h08);
        call_btn = 8'h00;
        tick(2);
        chk("t6_new_req", 32'(requested_floor), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
